// File: rtl/fft_peak_tracker_pkg.sv
// Shared types and helpers for the FFT peak tracker: sorted-slot entry,
// hysteresis states, width helpers and the bin-order bit reversal.
package fft_peak_pkg;

   // Widest magnitude / bin index a build may use; W must stay below MaxW
   localparam int MaxW     = 64;
   localparam int MaxNBits = 16;

   typedef struct packed {
      logic [MaxW-1:0]     mag;
      logic [MaxNBits-1:0] k;
      logic                valid;
   } peak_entry_t;

   typedef enum logic {
      IDLE,
      ACTIVE
   } track_state_e;

   function automatic int nbits_f(input int n);
      return $clog2(n);
   endfunction

   function automatic int cbits_f(input int np);
      return $clog2(np + 1);
   endfunction

   function automatic logic [MaxNBits-1:0] bit_rev(
      input logic [MaxNBits-1:0] v,
      input int                  n
   );
      logic [MaxNBits-1:0] r;
      r = '0;
      for (int b = 0; b < MaxNBits; b++) begin
         if (b < n) r[b] = v[4'(n - 1 - b)];
      end
      return r;
   endfunction

endpackage

// File: rtl/fft_peak_tracker_if.sv
// Sample stream, configuration and committed-peak bundle of the tracker.
interface fft_peak_tracker_if
   import fft_peak_pkg::*;
#(
   parameter int W        = 33,
   parameter int NSamples = 1024,
   parameter int NPeaks   = 4
);
   localparam int NBits = nbits_f(NSamples);
   localparam int CBits = cbits_f(NPeaks);

   logic [W-1:0]                 mag_i;
   logic                         mag_valid_i;
   logic [W-1:0]                 thr_on_i;
   logic [W-1:0]                 thr_off_i;
   logic [NBits-1:0]             bin_lo_i;
   logic [NBits-1:0]             bin_hi_i;
   logic [NPeaks-1:0][W-1:0]     peak_mag_o;
   logic [NPeaks-1:0][NBits-1:0] peak_k_o;
   logic [CBits-1:0]             peak_count_o;
   logic                         peak_valid_o;
   logic                         fire_o;
   logic                         release_o;
   logic                         active_o;

   modport master (
      output mag_i, mag_valid_i, thr_on_i, thr_off_i, bin_lo_i, bin_hi_i,
      input  peak_mag_o, peak_k_o, peak_count_o, peak_valid_o,
      input  fire_o, release_o, active_o
   );

   modport slave (
      input  mag_i, mag_valid_i, thr_on_i, thr_off_i, bin_lo_i, bin_hi_i,
      output peak_mag_o, peak_k_o, peak_count_o, peak_valid_o,
      output fire_o, release_o, active_o
   );

endinterface

// File: rtl/fft_peak_tracker_topk_insert.sv
// Combinational insert of one candidate into a descending sorted list.
module fft_topk_insert
   import fft_peak_pkg::*;
#(
   parameter int NPeaks = 4
) (
   input  peak_entry_t [NPeaks-1:0] list_i,
   input  peak_entry_t              cand_i,
   input  logic                     en_i,
   output peak_entry_t [NPeaks-1:0] list_o
);

   logic [NPeaks-1:0] below;

   // Strict compare keeps an equal earlier entry above the candidate
   for (genvar j = 0; j < NPeaks; j++) begin : g_slot
      assign below[j] = !list_i[j].valid || (list_i[j].mag < cand_i.mag);

      if (j == 0) begin : g_head
         assign list_o[j] = (en_i && below[j]) ? cand_i : list_i[j];
      end else begin : g_body
         assign list_o[j] = !(en_i && below[j]) ? list_i[j]
                          : below[j-1]          ? list_i[j-1]
                          :                       cand_i;
      end
   end

endmodule

// File: rtl/fft_peak_tracker.sv
// Per-window top-N spectral peak tracker with debounced on/off hysteresis.
module fft_peak_tracker
   import fft_peak_pkg::*;
#(
   parameter int NSamples  = 1024,
   parameter int W         = 33,
   parameter int NPeaks    = 4,
   parameter int BitRev    = 1,
   parameter int DebounceN = 2
) (
   input logic               clk,
   input logic               reset,
   fft_peak_tracker_if.slave bus
);

   localparam int NBits = nbits_f(NSamples);
   localparam int CBits = cbits_f(NPeaks);

   logic [NBits-1:0]             i_q, i_d;
   peak_entry_t [NPeaks-1:0]     list_q, list_d, list_ins;
   peak_entry_t                  cand;
   logic [MaxNBits-1:0]          k_rev;
   logic [NBits-1:0]             k;
   logic                         elig, last;
   logic [CBits-1:0]             cnt_ins;
   logic [W-1:0]                 top_mag;
   logic                         top_on;
   logic [3:0]                   deb_inc;
   logic                         unused_hi;

   logic [NPeaks-1:0][W-1:0]     pmag_q, pmag_d;
   logic [NPeaks-1:0][NBits-1:0] pk_q, pk_d;
   logic [CBits-1:0]             pcnt_q, pcnt_d;
   logic                         pv_q, pv_d;
   logic                         fire_q, fire_d;
   logic                         rel_q, rel_d;
   track_state_e                 state_q, state_d;
   logic [3:0]                   deb_q, deb_d;

   assign k_rev = bit_rev(MaxNBits'(i_q), NBits);
   assign k     = (BitRev != 0) ? k_rev[NBits-1:0] : i_q;
   assign last  = bus.mag_valid_i && (i_q == NBits'(NSamples - 1));
   assign elig  = bus.mag_valid_i
                && (k >= bus.bin_lo_i) && (k <= bus.bin_hi_i)
                && (bus.mag_i >= bus.thr_off_i);

   assign cand.mag   = MaxW'(bus.mag_i);
   assign cand.k     = MaxNBits'(k);
   assign cand.valid = 1'b1;

   fft_topk_insert #(
      .NPeaks (NPeaks)
   ) u_insert (
      .list_i (list_q),
      .cand_i (cand),
      .en_i   (elig),
      .list_o (list_ins)
   );

   always_comb begin
      cnt_ins = '0;
      for (int j = 0; j < NPeaks; j++) begin
         if (list_ins[j].valid) cnt_ins = cnt_ins + CBits'(1);
      end
   end

   always_comb begin
      unused_hi = ^k_rev[MaxNBits-1:NBits];
      for (int j = 0; j < NPeaks; j++) begin
         unused_hi = unused_hi
                   ^ (^list_ins[j].mag[MaxW-1:W])
                   ^ (^list_ins[j].k[MaxNBits-1:NBits]);
      end
   end

   // The commit publishes the list already updated with the final sample
   always_comb begin
      i_d    = i_q;
      list_d = list_q;
      pmag_d = pmag_q;
      pk_d   = pk_q;
      pcnt_d = pcnt_q;
      pv_d   = 1'b0;
      if (!bus.mag_valid_i) begin
         i_d    = '0;
         list_d = '0;
      end else if (last) begin
         i_d    = '0;
         list_d = '0;
         pv_d   = 1'b1;
         pcnt_d = cnt_ins;
         for (int j = 0; j < NPeaks; j++) begin
            pmag_d[j] = list_ins[j].valid ? list_ins[j].mag[W-1:0] : '0;
            pk_d[j]   = list_ins[j].valid ? list_ins[j].k[NBits-1:0] : '0;
         end
      end else begin
         i_d    = i_q + NBits'(1);
         list_d = list_ins;
      end
   end

   assign top_mag = list_ins[0].mag[W-1:0];
   assign top_on  = list_ins[0].valid && (top_mag >= bus.thr_on_i);
   assign deb_inc = (deb_q == 4'hF) ? deb_q : deb_q + 4'd1;

   always_comb begin
      state_d = state_q;
      deb_d   = deb_q;
      fire_d  = 1'b0;
      rel_d   = 1'b0;
      if (last) begin
         unique case (state_q)
            IDLE: begin
               if (!top_on) begin
                  deb_d = '0;
               end else if (deb_inc >= 4'(DebounceN)) begin
                  state_d = ACTIVE;
                  fire_d  = 1'b1;
                  deb_d   = '0;
               end else begin
                  deb_d = deb_inc;
               end
            end
            ACTIVE: begin
               if (!list_ins[0].valid || (top_mag < bus.thr_off_i)) begin
                  state_d = IDLE;
                  rel_d   = 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         i_q     <= '0;
         list_q  <= '0;
         pmag_q  <= '0;
         pk_q    <= '0;
         pcnt_q  <= '0;
         pv_q    <= 1'b0;
         fire_q  <= 1'b0;
         rel_q   <= 1'b0;
         state_q <= IDLE;
         deb_q   <= '0;
      end else begin
         i_q     <= i_d;
         list_q  <= list_d;
         pmag_q  <= pmag_d;
         pk_q    <= pk_d;
         pcnt_q  <= pcnt_d;
         pv_q    <= pv_d;
         fire_q  <= fire_d;
         rel_q   <= rel_d;
         state_q <= state_d;
         deb_q   <= deb_d;
      end
   end

   assign bus.peak_mag_o   = pmag_q;
   assign bus.peak_k_o     = pk_q;
   assign bus.peak_count_o = pcnt_q;
   assign bus.peak_valid_o = pv_q;
   assign bus.fire_o       = fire_q;
   assign bus.release_o    = rel_q;
   assign bus.active_o     = (state_q == ACTIVE);

endmodule

// File: tb/tb_fft_peak_tracker.sv
// Directed + random windows on a natural-order and a bit-reversed tracker.
module tb_fft_peak_tracker;
   import fft_peak_pkg::*;

   localparam int NS = 16;
   localparam int NB = 4;
   localparam int W  = 33;
   localparam int NP = 4;
   localparam int DB = 2;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   fft_peak_tracker_if #(.W(W), .NSamples(NS), .NPeaks(NP)) bn ();
   fft_peak_tracker_if #(.W(W), .NSamples(NS), .NPeaks(NP)) br ();

   fft_peak_tracker #(
      .NSamples(NS), .W(W), .NPeaks(NP), .BitRev(0), .DebounceN(DB)
   ) dut_nat (
      .clk(clk), .reset(reset), .bus(bn.slave)
   );

   fft_peak_tracker #(
      .NSamples(NS), .W(W), .NPeaks(NP), .BitRev(1), .DebounceN(DB)
   ) dut_rev (
      .clk(clk), .reset(reset), .bus(br.slave)
   );

   assign br.mag_i       = bn.mag_i;
   assign br.mag_valid_i = bn.mag_valid_i;
   assign br.thr_on_i    = bn.thr_on_i;
   assign br.thr_off_i   = bn.thr_off_i;
   assign br.bin_lo_i    = bn.bin_lo_i;
   assign br.bin_hi_i    = bn.bin_hi_i;

   int nvec = 0;
   int nerr = 0;

   logic [W-1:0] win [NS];
   logic [W-1:0] ton, toff;
   int           lo, hi;

   logic [W-1:0] exp_mag [2][NP];
   int           exp_k   [2][NP];
   int           exp_cnt [2];
   bit           m_act   [2];
   int           m_deb   [2];
   bit           exp_fire[2];
   bit           exp_rel [2];

   int s1k [NP] = '{7, 9, 15, 3};
   int s1m [NP] = '{90, 90, 70, 50};

   function automatic int brev(input int p);
      int r;
      r = 0;
      for (int b = 0; b < NB; b++) if (((p >> b) & 1) == 1) r |= 1 << (NB - 1 - b);
      return r;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      nvec++;
      assert (obs === expv) else begin
         nerr++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic set_cfg();
      bn.thr_on_i  = ton;
      bn.thr_off_i = toff;
      bn.bin_lo_i  = NB'(lo);
      bn.bin_hi_i  = NB'(hi);
   endtask

   // Top-N by magnitude, ties to the earlier arrival, then the on/off rules
   task automatic model_commit();
      for (int d = 0; d < 2; d++) begin
         bit used [NS];
         int best, kk;
         exp_cnt[d] = 0;
         for (int p = 0; p < NS; p++) used[p] = 1'b0;
         for (int j = 0; j < NP; j++) begin
            best = -1;
            for (int p = 0; p < NS; p++) begin
               kk = (d == 1) ? brev(p) : p;
               if (!used[p] && kk >= lo && kk <= hi && win[p] >= toff) begin
                  if (best < 0) best = p;
                  else if (win[p] > win[best]) best = p;
               end
            end
            exp_mag[d][j] = '0;
            exp_k[d][j]   = 0;
            if (best >= 0) begin
               used[best]    = 1'b1;
               exp_mag[d][j] = win[best];
               exp_k[d][j]   = (d == 1) ? brev(best) : best;
               exp_cnt[d]++;
            end
         end
         exp_fire[d] = 1'b0;
         exp_rel[d]  = 1'b0;
         if (!m_act[d]) begin
            if (exp_cnt[d] > 0 && exp_mag[d][0] >= ton)
               m_deb[d] = (m_deb[d] < 15) ? m_deb[d] + 1 : 15;
            else
               m_deb[d] = 0;
            if (m_deb[d] >= DB) begin
               m_act[d]    = 1'b1;
               exp_fire[d] = 1'b1;
               m_deb[d]    = 0;
            end
         end else if (exp_cnt[d] == 0 || exp_mag[d][0] < toff) begin
            m_act[d]   = 1'b0;
            exp_rel[d] = 1'b1;
         end
      end
   endtask

   task automatic check_commit(input string tag);
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("%s d%0d peak_valid", tag, d),
             d ? br.peak_valid_o : bn.peak_valid_o, 1);
         chk($sformatf("%s d%0d count", tag, d),
             d ? br.peak_count_o : bn.peak_count_o, exp_cnt[d]);
         chk($sformatf("%s d%0d fire", tag, d), d ? br.fire_o : bn.fire_o, exp_fire[d]);
         chk($sformatf("%s d%0d release", tag, d),
             d ? br.release_o : bn.release_o, exp_rel[d]);
         chk($sformatf("%s d%0d active", tag, d), d ? br.active_o : bn.active_o, m_act[d]);
         for (int j = 0; j < NP; j++) begin
            chk($sformatf("%s d%0d mag%0d", tag, d, j),
                d ? br.peak_mag_o[j] : bn.peak_mag_o[j], exp_mag[d][j]);
            chk($sformatf("%s d%0d k%0d", tag, d, j),
                d ? br.peak_k_o[j] : bn.peak_k_o[j], exp_k[d][j]);
         end
      end
   endtask

   task automatic chk_quiet(input string tag);
      chk(tag, {bn.peak_valid_o, bn.fire_o, bn.release_o,
                br.peak_valid_o, br.fire_o, br.release_o}, 0);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, " nat ctl"}, {bn.peak_valid_o, bn.fire_o, bn.release_o,
                              bn.active_o, bn.peak_count_o}, 0);
      chk({tag, " rev ctl"}, {br.peak_valid_o, br.fire_o, br.release_o,
                              br.active_o, br.peak_count_o}, 0);
      chk({tag, " nat data"}, {bn.peak_mag_o, bn.peak_k_o}, 0);
      chk({tag, " rev data"}, {br.peak_mag_o, br.peak_k_o}, 0);
   endtask

   // Called at a negedge; returns at the negedge that shows the commit
   task automatic send_window(input string tag);
      set_cfg();
      for (int p = 0; p < NS; p++) begin
         if (p > 0) chk_quiet({tag, " mid"});
         bn.mag_i       = win[p];
         bn.mag_valid_i = 1'b1;
         @(negedge clk);
      end
      model_commit();
      check_commit(tag);
   endtask

   task automatic idle_cycle(input string tag);
      bn.mag_valid_i = 1'b0;
      @(negedge clk);
      chk_quiet({tag, " idle"});
   endtask

   task automatic fill_bg(input int maxv);
      for (int p = 0; p < NS; p++) win[p] = W'($urandom_range(0, maxv));
   endtask

   initial begin
      logic [W-1:0] sc;
      bit           wide;
      reset          = 1'b1;
      bn.mag_i       = '0;
      bn.mag_valid_i = 1'b0;
      ton = '0; toff = '0; lo = 0; hi = NS - 1;
      set_cfg();
      for (int d = 0; d < 2; d++) begin m_act[d] = 1'b0; m_deb[d] = 0; end
      repeat (2) @(negedge clk);
      chk_zero("reset");
      reset = 1'b0;
      @(negedge clk);

      // Scenario 1: natural-order ranking with a tie
      ton = {W{1'b1}}; toff = 1; lo = 0; hi = NS - 1;
      for (int p = 0; p < NS; p++) win[p] = '0;
      win[3] = 50; win[7] = 90; win[9] = 90; win[12] = 20; win[15] = 70;
      send_window("s1");
      for (int j = 0; j < NP; j++) begin
         chk($sformatf("s1 const k%0d", j), bn.peak_k_o[j], s1k[j]);
         chk($sformatf("s1 const mag%0d", j), bn.peak_mag_o[j], s1m[j]);
      end
      idle_cycle("s1");

      // Scenario 2: bit-reversed bin of stream position 1
      toff = 0;
      fill_bg(100);
      win[1] = 500;
      send_window("s2");
      chk("s2 rev k0", br.peak_k_o[0], 8);
      idle_cycle("s2");

      // Scenario 3: bin window excludes the largest, then nothing qualifies
      lo = 2; hi = 5; toff = 1;
      fill_bg(100);
      win[10] = 900;
      send_window("s3a");
      idle_cycle("s3a");
      toff = 1000;
      send_window("s3b");
      chk("s3b count", {bn.peak_count_o, br.peak_count_o}, 0);
      idle_cycle("s3b");

      // Scenario 4: debounce, hold, release
      ton = 1000; toff = 400; lo = 0; hi = NS - 1;
      for (int w = 0; w < 4; w++) begin
         fill_bg(300);
         win[$urandom_range(0, NS - 1)] = (w < 2) ? 1200 : (w == 2) ? 800 : 300;
         send_window($sformatf("s4w%0d", w));
      end
      idle_cycle("s4");

      // Scenario 5: abort at sample 9, then a clean window
      ton = {W{1'b1}}; toff = 1;
      fill_bg(200);
      set_cfg();
      for (int p = 0; p < 9; p++) begin
         bn.mag_i = 33'd999; bn.mag_valid_i = 1'b1;
         @(negedge clk);
      end
      idle_cycle("s5 abort");
      chk("s5 hold count", bn.peak_count_o, exp_cnt[0]);
      send_window("s5");
      idle_cycle("s5");

      // Scenario 6: asynchronous reset while active, mid-window
      ton = 1000; toff = 400;
      for (int w = 0; w < 2; w++) begin
         fill_bg(300);
         win[w + 3] = 1200;
         send_window($sformatf("s6pre%0d", w));
      end
      chk("s6 active", {bn.active_o, br.active_o}, 2'b11);
      for (int p = 0; p < 5; p++) begin
         bn.mag_i = 33'd1500; bn.mag_valid_i = 1'b1;
         @(negedge clk);
      end
      #2 reset = 1'b1;
      bn.mag_valid_i = 1'b0;
      #1 chk_zero("s6 async");
      for (int d = 0; d < 2; d++) begin m_act[d] = 1'b0; m_deb[d] = 0; end
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      fill_bg(300);
      win[6] = 1200;
      send_window("s6post");
      idle_cycle("s6post");

      // Random windows, some back-to-back, some using the top bits of W
      for (int r = 0; r < 14; r++) begin
         wide = ($urandom_range(0, 1) == 1);
         sc   = wide ? (W'(1) << 27) : W'(1);
         lo   = $urandom_range(0, 7);
         hi   = $urandom_range(lo, NS - 1);
         toff = W'($urandom_range(0, 25)) * sc;
         ton  = toff + W'($urandom_range(0, 30)) * sc;
         for (int p = 0; p < NS; p++) win[p] = W'($urandom_range(0, 60)) * sc;
         send_window($sformatf("rnd%0d", r));
         if ($urandom_range(0, 1) == 1) idle_cycle("rnd");
      end
      idle_cycle("end");

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/fft_peak_tracker.md
FFT_PEAK_TRACKER -- requirements
Module: fft_peak_tracker

Interface
REQ-001 Parameter NSamples, default 1024: FFT points per window, power of two, at least 4.
REQ-002 Parameter W, default 33: magnitude-squared width.
REQ-003 Parameter NPeaks, default 4: peaks tracked per window, 1..8.
REQ-004 Parameter BitRev, default 1: 1 means input arrives in bit-reversed order; 0 means natural order.
REQ-005 Parameter DebounceN, default 2: consecutive qualifying windows needed before fire, 1..15.
REQ-006 Derived NBits = clog2(NSamples); CBits = clog2(NPeaks+1).
REQ-007 clk  input  1  sole clock; all logic on its rising edge.
REQ-008 reset  input  1  asynchronous, active-high reset.
REQ-009 mag  input  W  unsigned magnitude-squared sample.
REQ-010 mag_valid  input  1  sample strobe; windows are contiguous runs of high cycles.
REQ-011 thr_on  input  W  activation threshold, sampled at commit.
REQ-012 thr_off  input  W  release/eligibility threshold, sampled at commit and per sample; thr_off <= thr_on is required.
REQ-013 bin_lo, bin_hi  input  NBits each  inclusive eligible bin range in natural order.
REQ-014 peak_mag  output  NPeaks x W  committed magnitudes, index 0 is the largest.
REQ-015 peak_k  output  NPeaks x NBits  committed natural-order bin indices.
REQ-016 peak_count  output  CBits  number of valid committed entries.
REQ-017 peak_valid  output  1  one-cycle commit pulse.
REQ-018 fire / release  output  1 each  one-cycle activation / deactivation pulses.
REQ-019 active  output  1  hysteresis state level.

Function
REQ-020 Sample counter i increments on each mag_valid cycle; k = bit-reverse(i) if BitRev, else i.
REQ-021 A sample is eligible iff bin_lo <= k <= bin_hi and mag >= thr_off.
REQ-022 Eligible samples insert into a descending sorted working list of NPeaks entries.
REQ-023 Insertion point is the first entry whose mag is strictly less than the sample, or the first invalid entry; lower entries shift down and the last drops.
REQ-024 Equal magnitudes keep arrival order: the earlier sample ranks higher.
REQ-025 The final sample (i = NSamples-1) is included in the commit; outputs register the list updated with that sample.
REQ-026 peak_valid pulses the cycle after the final sample; the working list clears and i returns to 0 in that same edge.
REQ-027 A sample on the cycle immediately following the final sample is sample 0 of the next window, with no gap required.
REQ-028 mag_valid low mid-window aborts the window: i=0, list cleared, outputs unchanged, no pulses, debounce count unchanged.
REQ-029 Invalid output entries read mag=0, k=0.
REQ-030 Hysteresis FSM states are IDLE (active=0) and ACTIVE (active=1), evaluated only at commit.
REQ-031 In IDLE, a window whose top entry is valid and >= thr_on increments the debounce count (saturating at 15); otherwise the count resets to 0.
REQ-032 In IDLE, when the count reaches DebounceN, go to ACTIVE, pulse fire together with peak_valid, and clear the count.
REQ-033 In ACTIVE, if peak_count = 0 or the top entry is < thr_off, go to IDLE and pulse release together with peak_valid; otherwise stay.
REQ-034 fire and release never assert in the same cycle, and each lasts exactly one cycle.
REQ-035 All comparisons are unsigned at full width W with no truncation.

Reset
REQ-036 Reset clears i, the working list, all outputs, the debounce count and the FSM (IDLE); asserting reset mid-window discards the partial window.
REQ-037 The first sample after reset release is sample 0.

Structure
REQ-038 Package fft_peak_pkg holds peak_entry_t (mag, k, valid), a bit-reverse function and the NBits/CBits helper functions.
REQ-039 Sub-module fft_topk_insert is the combinational single-candidate sorted insert, instantiated once.

Verification
REQ-040 Scenario 1: NSamples=16, BitRev=0, NPeaks=4, bins 0..15, thr_off=1; natural-order magnitudes with bins 3=50, 7=90, 9=90, 12=20, 15=70 -> one cycle after sample 15, peak_valid=1, peak_k = {7,9,15,3}, peak_mag = {90,90,70,50}, peak_count=4.
REQ-041 Scenario 2: BitRev=1, largest value 500 placed at stream position 1 -> peak_k[0]=8.
REQ-042 Scenario 3: bin_lo=2, bin_hi=5, largest value at bin 10 -> bin 10 is excluded; thr_off above all magnitudes -> peak_count=0.
REQ-043 Scenario 4: DebounceN=2, thr_on=1000, thr_off=400; top peaks per window 1200, 1200, 800, 300 -> fire at window 2 commit, active stays high at window 3, release at window 4 commit.
REQ-044 Scenario 5: mag_valid drops at sample 9, then a full window -> only one peak_valid, carrying second-window data.
REQ-045 Scenario 6: reset asserted at sample 5 with active=1 -> all outputs 0 asynchronously, and the next full window commits normally.
